gray_count_sampler: RTL and testbench
=====================================

GRAY_COUNT_SAMPLER -- requirements
Module: gray_count_sampler

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent gray-coded counter inputs.
REQ-002 Parameter WIDTH, default 32: counter width in bits, legal range 4..32.
REQ-003 Parameter STAGES, default 2: synchroniser flip-flop depth, legal range 2..4.
REQ-004 Parameter PERIOD_W, default 32: width of gate-period input.
REQ-005 clk  input  1: single clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1: reset, asynchronous, active-high.
REQ-007 enable_i  input  1: run measurement while high.
REQ-008 gate_period_i  input  PERIOD_W: gate window length in clk cycles.
REQ-009 gray_i  input  CHANNELS x WIDTH: gray-coded counts, each driven directly from a register in a foreign clock domain.
REQ-010 count_o  output  CHANNELS x WIDTH: counts accumulated per channel over the last completed window.
REQ-011 valid_o  output  1: one-cycle strobe, count_o/err_o updated this cycle.
REQ-012 err_o  output  CHANNELS: per channel, a gray violation occurred in the reported window.
REQ-013 busy_o  output  1: state is not IDLE.

Function
REQ-014 Each gray_i channel SHALL pass through STAGES flip-flops clocked by clk, then gray-to-binary conversion, registered once; latency gray_i to binary value = STAGES+1 cycles.
REQ-015 State machine states IDLE, PRIME, MEASURE; IDLE->PRIME when enable_i high; PRIME->MEASURE at first terminal count; any state->IDLE in the cycle after enable_i is sampled low.
REQ-016 gate_period_i SHALL be sampled only on the IDLE->PRIME transition; values below 2 SHALL be treated as 2.
REQ-017 Gate counter SHALL run 0..P-1 in PRIME and MEASURE, wrapping to 0; terminal count is P-1.
REQ-018 At every terminal count each channel SHALL snapshot its binary value into a reference register.
REQ-019 At terminal count in MEASURE, count_o[ch] SHALL equal current binary minus reference, modulo 2^WIDTH, and valid_o SHALL pulse high exactly one cycle, same cycle for all channels.
REQ-020 Terminal count in PRIME SHALL NOT assert valid_o (first window discarded).
REQ-021 Counter wrap-around (e.g. 2^WIDTH-3 to 5) SHALL yield the correct modular difference (8).
REQ-022 Gray violation: synchronised gray value differing from previous cycle in more than one bit SHALL set a sticky per-channel flag.
REQ-023 err_o SHALL load the sticky flags at valid_o; sticky flags SHALL clear at every terminal count, a violation in that same cycle seeding the new window.
REQ-024 enable_i dropping mid-window SHALL abort without valid_o; count_o and err_o SHALL hold last values.
REQ-025 Re-enable SHALL restart from PRIME with freshly sampled gate_period_i.
REQ-026 Between strobes count_o and err_o SHALL be stable.

Reset
REQ-027 On rst: state IDLE, gate counter 0, all synchroniser stages, binary, reference and sticky registers 0, count_o 0, err_o 0, valid_o 0, busy_o 0.
REQ-028 rst mid-window SHALL abort immediately; no valid_o until a full PRIME plus MEASURE window after release with enable_i high.

Structure
REQ-029 Package freq_counter_pkg SHALL hold the state enum and a gray-to-binary function parametrised by width.
REQ-030 One sub-module, sync_chain (parameters WIDTH, STAGES), SHALL implement one channel's flip-flop chain, instantiated CHANNELS times.

Verification
REQ-031 P=100, ch0 gray incrementing 1 per 4 clk, enable held -> first valid_o after 200 cycles plus latency, count_o[0]=25, err_o=0.
REQ-032 ch1 binary starting 2^32-10, 1 per clk, P=20 -> count_o[1]=20 across wrap.
REQ-033 Inject gray jump 0b0000->0b0011 on ch2 mid-window -> err_o[2]=1 at that strobe, 0 at following strobe.
REQ-034 Drop enable_i at cycle 50 of P=100 window -> no valid_o, count_o unchanged, busy_o low next cycle.
REQ-035 gate_period_i=0 -> windows of 2 cycles, valid_o every 2nd cycle in MEASURE.
REQ-036 Assert rst during MEASURE -> all outputs 0 immediately, valid_o absent until 2P cycles after release.

Source files
------------

// File: rtl/freq_counter_pkg.sv
// freq_counter_pkg: FSM states and gray decoding shared by gray_count_sampler
package freq_counter_pkg;
  localparam int G_MAX_W = 32;
  typedef enum logic [1:0] {IDLE, PRIME, MEASURE} state_t;
  function automatic logic [G_MAX_W-1:0] gray2bin(input logic [G_MAX_W-1:0] g);
    gray2bin = g;
    for (int i = G_MAX_W - 2; i >= 0; i--) gray2bin[i] = gray2bin[i+1] ^ g[i];
  endfunction
endpackage

// File: rtl/sync_chain.sv
// sync_chain: STAGES-deep flip-flop synchroniser for one gray-coded channel
module sync_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] s;
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= '0;
    else s <= {s[STAGES-2:0], d};
  assign q = s[STAGES-1];
endmodule

// File: rtl/gray_count_sampler.sv
// gray_count_sampler: per-window increment of foreign-domain gray counters with gray-violation flags
module gray_count_sampler
  import freq_counter_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int STAGES   = 2,
  parameter int PERIOD_W = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable_i,
  input  logic [PERIOD_W-1:0]            gate_period_i,
  input  logic [CHANNELS-1:0][WIDTH-1:0] gray_i,
  output logic [CHANNELS-1:0][WIDTH-1:0] count_o,
  output logic                           valid_o,
  output logic [CHANNELS-1:0]            err_o,
  output logic                           busy_o
);
  state_t                        state;
  logic [PERIOD_W-1:0]           period, gate_cnt;
  logic [CHANNELS-1:0][WIDTH-1:0] sync, prev, bin, ref_q;
  logic [CHANNELS-1:0]           viol, sticky;
  logic                          tc;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    sync_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) u_sync (
      .clk(clk), .rst(rst), .d(gray_i[c]), .q(sync[c])
    );
  end
  always_comb begin
    viol = '0;
    for (int i = 0; i < CHANNELS; i++) viol[i] = $countones(sync[i] ^ prev[i]) > 1;
  end
  assign tc     = state != IDLE && gate_cnt == period - PERIOD_W'(1);
  assign busy_o = state != IDLE;
  // a violation seen on a terminal-count cycle belongs to the window that starts there
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev   <= '0;
      bin    <= '0;
      ref_q  <= '0;
      sticky <= '0;
    end else begin
      prev <= sync;
      for (int i = 0; i < CHANNELS; i++) bin[i] <= WIDTH'(gray2bin(G_MAX_W'(sync[i])));
      if (tc) ref_q <= bin;
      sticky <= tc ? viol : sticky | viol;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      period   <= PERIOD_W'(2);
      gate_cnt <= '0;
      count_o  <= '0;
      err_o    <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (state == IDLE) begin
        gate_cnt <= '0;
        if (enable_i) begin
          state  <= PRIME;
          period <= gate_period_i < PERIOD_W'(2) ? PERIOD_W'(2) : gate_period_i;
        end
      end else if (!enable_i) begin
        state    <= IDLE;
        gate_cnt <= '0;
      end else begin
        gate_cnt <= tc ? '0 : gate_cnt + PERIOD_W'(1);
        if (tc && state == PRIME) state <= MEASURE;
        if (tc && state == MEASURE) begin
          valid_o <= 1'b1;
          err_o   <= sticky;
          for (int i = 0; i < CHANNELS; i++) count_o[i] <= bin[i] - ref_q[i];
        end
      end
    end
endmodule

// File: tb/tb_gray_count_sampler.sv
// tb_gray_count_sampler: randomized scoreboard bench against a window-arithmetic reference model
module tb_gray_count_sampler;
  localparam int CH = 4, W = 32, ST = 2, PW = 32, LAT = ST + 1, MAXC = 12000, BW = CH * W;
  logic clk = 0, rst = 1, enable = 0;
  logic [PW-1:0] gp = '0;
  logic [CH-1:0][W-1:0] gray = '0, count;
  logic [CH-1:0] err;
  logic valid, busy;
  gray_count_sampler #(.CHANNELS(CH), .WIDTH(W), .STAGES(ST), .PERIOD_W(PW)) dut (
    .clk(clk), .rst(rst), .enable_i(enable), .gate_period_i(gp), .gray_i(gray),
    .count_o(count), .valid_o(valid), .err_o(err), .busy_o(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    int cyc;
    logic [CH-1:0][W-1:0] cnt;
    logic [CH-1:0] err;
  } exp_t;
  exp_t sb[$];
  int compared = 0, mismatched = 0, cyc = 0;
  logic [W-1:0] hb[CH][MAXC];
  logic [W-1:0] b[CH];
  bit running = 0, exp_busy = 0;
  int s = 0, per = 2;
  logic [CH-1:0][W-1:0] hold_cnt = '0;
  logic [CH-1:0] hold_err = '0;
  initial forever @(posedge clk) cyc++;
  function automatic logic [W-1:0] hbin(int c, int i);
    return i < 0 ? '0 : hb[c][i];
  endfunction
  function automatic logic [W-1:0] hgray(int c, int i);
    logic [W-1:0] v = hbin(c, i);
    return v ^ (v >> 1);
  endfunction
  task automatic chk(string nm, logic [BW-1:0] act, logic [BW-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, req);
    end
  endtask
  // one clock cycle of stimulus; the model predicts the strobe this cycle's terminal count produces
  task automatic step(bit e, logic [PW-1:0] g, bit r, bit j);
    int n;
    exp_t x;
    @(negedge clk);
    n = cyc;
    if (n >= MAXC) begin
      $display("FAIL cycle_budget: cycle %0d reached limit %0d", n, MAXC);
      $fatal(1);
    end
    enable = e;
    gp = g;
    rst = r;
    b[0] = b[0] + W'((n % 4 == 0) ? 1 : 0);
    b[1] = b[1] + W'(1);
    b[2] = b[2] + (j ? W'(2) : W'($urandom_range(0, 1)));
    b[3] = b[3] + W'(($urandom_range(0, 2) == 0) ? 1 : 0);
    for (int c = 0; c < CH; c++) begin
      gray[c] = b[c] ^ (b[c] >> 1);
      hb[c][n] = r ? '0 : b[c];
    end
    if (running && !r && e && (n - s) % per == per - 1 && (n - s) / per >= 1) begin
      x.cyc = n + 1;
      for (int c = 0; c < CH; c++) begin
        x.cnt[c] = hbin(c, n - LAT) - hbin(c, n - per - LAT);
        x.err[c] = 1'b0;
        for (int m = n - per - LAT + 1; m <= n - LAT; m++)
          if ($countones(hgray(c, m) ^ hgray(c, m - 1)) > 1) x.err[c] = 1'b1;
      end
      sb.push_back(x);
    end
    if (r) running = 0;
    else if (!running) begin
      if (e) begin
        running = 1;
        s = n + 1;
        per = (g < 2) ? 2 : int'(g);
      end
    end else if (!e) running = 0;
    exp_busy = running;
  endtask
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        hold_cnt = '0;
        hold_err = '0;
      end
      chk("busy", BW'(busy), BW'(exp_busy));
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        x = sb.pop_front();
        chk("valid", BW'(valid), BW'(1));
        chk("count", BW'(count), BW'(x.cnt));
        chk("err", BW'(err), BW'(x.err));
        hold_cnt = x.cnt;
        hold_err = x.err;
      end else begin
        chk("no_valid", BW'(valid), BW'(0));
        chk("count_hold", BW'(count), BW'(hold_cnt));
        chk("err_hold", BW'(err), BW'(hold_err));
      end
    end
  end
  initial begin
    for (int c = 0; c < CH; c++) begin
      for (int i = 0; i < MAXC; i++) hb[c][i] = '0;
      b[c] = '0;
    end
    b[1] = 32'hFFFF_FFF6;
    repeat (3) step(0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0);
    repeat (330) step(1, 100, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    repeat (250) step(1, 100, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    b[1] = 32'hFFFF_FFF6 - 32'd24;
    repeat (3) step(0, 0, 0, 0);
    repeat (80) step(1, 20, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    for (int k = 0; k < 100; k++) step(1, 30, 0, k == 45);
    repeat (3) step(0, 0, 0, 0);
    repeat (20) step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (25) step(1, 10, 0, 0);
    repeat (3) step(1, 10, 1, 0);
    repeat (40) step(1, 10, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (25) begin
      int len = $urandom_range(1, 150);
      step(0, PW'($urandom_range(0, 40)), 0, 0);
      repeat (len) step(1, PW'($urandom_range(0, 40)), 0, $urandom_range(0, 199) == 0);
      repeat ($urandom_range(1, 4)) step(0, 0, 0, 0);
    end
    repeat (5) step(0, 0, 0, 0);
    chk("drain", BW'(sb.size()), BW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
